// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared widths, NOP encoding and FSM state type for the fetch stage
package if_fetch_unit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0,x0,0: the bubble presented to IF/ID when no instruction is held
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,   // request outstanding to imem, waiting for gnt
    WAIT = 2'd1,   // granted, waiting for rvalid
    HOLD = 2'd2    // instruction presented to IF/ID, waiting for fetch_ready
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/response bus between fetch and imem
// Signals:
//   req    fetch -> imem  request valid
//   addr   fetch -> imem  request address, stable while req && !gnt
//   gnt    imem -> fetch  request accepted this cycle
//   rvalid imem -> fetch  read data valid, at least one cycle after gnt
//   rdata  imem -> fetch  instruction word
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, imem requests, IF/ID writer with stall and redirect
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-high reset
//   fetch_ready        IF/ID write enable from the hazard unit (0 = stall)
//   branch_taken       one-cycle redirect from EX; wins over every other event
//   branch_target      redirect PC, low two bits ignored
//   imem               instruction-memory bus (master side), one request in flight at most
//   fetch_valid        fetch_pc/fetch_instr hold a real instruction
//   fetch_pc           PC of the presented instruction
//   fetch_instr        presented instruction, NOP_INSTR whenever fetch_valid is low
//   stall_count        cycles spent holding a valid instruction that IF/ID refused
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_ready,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  if_fetch_unit_if.master   imem,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_pc,
  output logic [ILEN-1:0]   fetch_instr,
  output logic [31:0]       stall_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            valid_d;
  logic            capture;
  logic            req_c;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] target;

  assign target = branch_target & ~XLEN'(3);

  // Reset gates the request so nothing escapes while reset is held.
  assign imem.req  = req_c & ~reset;
  assign imem.addr = pc_q;

  assign fetch_instr = fetch_valid ? instr_q : NOP_INSTR;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = fetch_valid;
    capture = 1'b0;
    req_c   = 1'b0;
    unique case (state_q)
      REQ: begin
        req_c = 1'b1;
        if (branch_taken) begin
          pc_d = target;
          // A grant coinciding with the redirect still leaves a response in
          // flight for the stale address; wait it out and throw it away.
          if (imem.gnt) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem.gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          pc_d = target;
          if (imem.rvalid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem.rvalid) begin
          if (drop_q) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            capture = 1'b1;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (fetch_ready) begin
          pc_d    = pc_q + XLEN'(4);
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      instr_q     <= NOP_INSTR;
      stall_count <= '0;
    end else begin
      fetch_valid <= valid_d;
      if (capture) begin
        fetch_pc <= pc_q;
        instr_q  <= imem.rdata;
      end
      if (fetch_valid && !fetch_ready && !branch_taken) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic [31:0] stall_count;

  if_fetch_unit_if imem();

  if_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_ready   (fetch_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_instr   (fetch_instr),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // memory responder state
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;

  // program-order reference model
  logic [63:0] exp_pc = 64'h0;
  logic [31:0] exp_stall = 32'd0;
  bit          prev_wait = 1'b0;
  logic [63:0] prev_addr = '0;

  // values sampled at the falling edge of the last cycle
  logic        s_valid, s_req;
  logic [63:0] s_pc, s_addr;
  logic [31:0] s_instr, s_stall;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'hA5C3_0F17 ^ a[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample/check at the falling edge, advance the models.
  task automatic tick(input bit rdy, input bit br, input logic [63:0] tgt);
    fetch_ready   = rdy;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    imem.rvalid = pend && (pend_cnt == 0);
    imem.rdata  = imem.rvalid ? mem_word(pend_addr) : $urandom;
    imem.gnt    = imem.req && (int'($urandom_range(99)) < gnt_pct);
    @(negedge clock);
    s_valid = fetch_valid;
    s_pc    = fetch_pc;
    s_instr = fetch_instr;
    s_req   = imem.req;
    s_addr  = imem.addr;
    s_stall = stall_count;
    if (!s_valid) begin
      chk("nop_when_invalid", s_instr, NOP_INSTR);
    end else begin
      chk("fetch_pc", s_pc, exp_pc);
      chk("fetch_instr", s_instr, mem_word(exp_pc));
    end
    chk("stall_count", s_stall, exp_stall);
    if (prev_wait) begin
      chk("req_held", s_req, 1);
      chk("addr_stable", s_addr, prev_addr);
    end
    if (s_valid && !rdy && !br) exp_stall++;
    if (br) exp_pc = tgt & ~64'h3;
    else if (s_valid && rdy) exp_pc = exp_pc + 64'd4;
    prev_wait = s_req && !imem.gnt && !br;
    prev_addr = s_addr;
    if (imem.rvalid) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (s_req && imem.gnt) begin
      pend      = 1'b1;
      pend_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      pend_addr = s_addr;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input bit rdy, output int n);
    bit got = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick(rdy, 1'b0, 64'h0);
      n++;
      got = s_valid;
    end
    chk("wait_valid_timeout", got, 1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_valid", fetch_valid, 0);
    chk("reset_pc", fetch_pc, 0);
    chk("reset_instr", fetch_instr, 32'h0000_0013);
    chk("reset_req", imem.req, 0);
    chk("reset_stall", stall_count, 0);
    reset = 1'b0;

    // 1: back-to-back fetches, gnt immediate, rvalid one cycle later
    wait_valid(1'b1, n);
    chk("t1_latency", n, 3);
    chk("t1_pc0", s_pc, 64'h0);
    chk("t1_instr0", s_instr, mem_word(64'h0));
    wait_valid(1'b1, n);
    chk("t1_pc4", s_pc, 64'h4);

    // 2: stall in HOLD at pc 8 for five cycles
    wait_valid(1'b0, n);
    chk("t2_pc8", s_pc, 64'h8);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 64'h0);
      chk("t2_no_req", s_req, 0);
      chk("t2_pc_stable", s_pc, 64'h8);
    end
    tick(1'b1, 1'b0, 64'h0);
    chk("t2_stall5", s_stall, 5);

    // 3: redirect during WAIT with a late response
    lat_min = 3;
    lat_max = 3;
    tick(1'b1, 1'b0, 64'h0);
    chk("t3_req_granted", s_req, 1);
    tick(1'b1, 1'b1, 64'h103);
    chk("t3_in_wait", s_req, 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1'b0, 1'b0, 64'h0);
      got = s_req;
    end
    chk("t3_req_back", got, 1);
    chk("t3_addr", s_addr, 64'h100);
    wait_valid(1'b0, n);
    chk("t3_pc", s_pc, 64'h100);

    // 4: redirect and fetch_ready together in HOLD
    lat_min = 1;
    lat_max = 1;
    tick(1'b1, 1'b1, 64'h200);
    tick(1'b1, 1'b0, 64'h0);
    chk("t4_dropped", s_valid, 0);
    wait_valid(1'b1, n);
    chk("t4_pc", s_pc, 64'h200);

    // 5: grant withheld for four cycles
    gnt_pct = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 64'h0);
      chk("t5_req", s_req, 1);
      chk("t5_addr", s_addr, 64'h204);
      chk("t5_valid", s_valid, 0);
      chk("t5_instr", s_instr, 32'h0000_0013);
    end
    gnt_pct = 100;

    // 6: asynchronous reset while in WAIT
    tick(1'b1, 1'b0, 64'h0);
    chk("t6_granted", s_req, 1);
    reset = 1'b1;
    #1;
    chk("t6_valid", fetch_valid, 0);
    chk("t6_pc", fetch_pc, 0);
    chk("t6_instr", fetch_instr, 32'h0000_0013);
    chk("t6_req", imem.req, 0);
    chk("t6_stall", stall_count, 0);
    pend        = 1'b0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    exp_pc      = 64'h0;
    exp_stall   = 32'd0;
    prev_wait   = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_valid(1'b1, n);
    chk("t6_restart_latency", n, 3);
    chk("t6_restart_pc", s_pc, 64'h0);

    // 7: randomized traffic against the program-order model
    gnt_pct = 60;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      tick(int'($urandom_range(99)) < 70, int'($urandom_range(99)) < 6,
           {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
